// File: rtl/rpsc_ps_sequencer.sv
// Power-supply turn-on/turn-off sequencer: G1 first, anode after a settle time,
// ordered shutdown, and a first-fault latch held until the operator clears it.
module rpsc_ps_sequencer #(
    parameter int CNT_W      = 23,
    parameter int G1_TIMEOUT = 3125000,
    parameter int AN_DELAY   = 781250,
    parameter int AN_TIMEOUT = 4687500,
    parameter int OFF_DELAY  = 390625
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start_req,
    input  logic       i_stop_req,
    input  logic       i_fault_clear,
    input  logic       i_g1_not_alarm,
    input  logic       i_not_g1_ok,
    input  logic       i_an_not_alarm,
    input  logic       i_an_perm,
    input  logic       i_an_ok,
    output logic       o_g1_ps_act,
    output logic       o_an_ps_act,
    output logic       o_running,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_G1_RAMP  = 3'd1,
        S_AN_WAIT  = 3'd2,
        S_AN_RAMP  = 3'd3,
        S_RUN      = 3'd4,
        S_SHUTDOWN = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    // Counter value seen on the P-th cycle spent in a state.
    localparam logic [CNT_W-1:0] G1_EXP  = CNT_W'(G1_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AND_EXP = CNT_W'(AN_DELAY - 1);
    localparam logic [CNT_W-1:0] ANT_EXP = CNT_W'(AN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OFF_EXP = CNT_W'(OFF_DELAY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (i_start_req && i_g1_not_alarm && i_an_not_alarm)
                    state_d = S_G1_RAMP;
            end
            S_G1_RAMP, S_AN_WAIT, S_AN_RAMP, S_RUN: begin
                // Alarm checks outrank stop and the per-state progress rules.
                if (!i_g1_not_alarm) begin
                    state_d = S_FAULT;
                    code_d  = 3'd1;
                end else if (state_q != S_G1_RAMP && !i_an_not_alarm) begin
                    state_d = S_FAULT;
                    code_d  = 3'd3;
                end else if (state_q == S_RUN && i_not_g1_ok) begin
                    state_d = S_FAULT;
                    code_d  = 3'd5;
                end else if (state_q == S_RUN && !i_an_ok) begin
                    state_d = S_FAULT;
                    code_d  = 3'd6;
                end else if (i_stop_req) begin
                    state_d = S_SHUTDOWN;
                end else if (state_q == S_G1_RAMP) begin
                    if (!i_not_g1_ok) begin
                        state_d = S_AN_WAIT;
                    end else if (cnt_q == G1_EXP) begin
                        state_d = S_FAULT;
                        code_d  = 3'd2;
                    end
                end else if (state_q == S_AN_WAIT) begin
                    if (cnt_q == AND_EXP) begin
                        if (i_an_perm) begin
                            state_d = S_AN_RAMP;
                        end else begin
                            state_d = S_FAULT;
                            code_d  = 3'd3;
                        end
                    end
                end else if (state_q == S_AN_RAMP) begin
                    if (i_an_ok) begin
                        state_d = S_RUN;
                    end else if (cnt_q == ANT_EXP) begin
                        state_d = S_FAULT;
                        code_d  = 3'd4;
                    end
                end
            end
            S_SHUTDOWN: begin
                if (!i_g1_not_alarm) begin
                    state_d = S_FAULT;
                    code_d  = 3'd1;
                end else if (cnt_q == OFF_EXP) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (i_fault_clear && i_g1_not_alarm && i_an_not_alarm) begin
                    state_d = S_IDLE;
                    code_d  = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == '1)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign o_g1_ps_act  = (state_q == S_G1_RAMP) || (state_q == S_AN_WAIT) ||
                          (state_q == S_AN_RAMP) || (state_q == S_RUN) ||
                          (state_q == S_SHUTDOWN);
    assign o_an_ps_act  = (state_q == S_AN_RAMP) || (state_q == S_RUN);
    assign o_running    = (state_q == S_RUN);
    assign o_fault      = (state_q == S_FAULT);
    assign o_fault_code = code_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_rpsc_ps_sequencer.sv
// Bench for rpsc_ps_sequencer: directed scenarios with literal expectations, then
// randomized stimulus, all cycles checked against a timestamp-based behavioural model.
module tb_rpsc_ps_sequencer;

    localparam int G1_TO  = 20;
    localparam int AN_DLY = 5;
    localparam int AN_TO  = 30;
    localparam int OFF_DL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_req, stop_req, fault_clear;
    logic       g1_not_alarm, not_g1_ok, an_not_alarm, an_perm, an_ok;
    logic       g1_act, an_act, running, fault;
    logic [2:0] fault_code, state;

    int tests  = 0;
    int errors = 0;

    // Model: current state number, latched code, edge counter and entry edge.
    int m_state = 0;
    int m_code  = 0;
    int m_edge  = 0;
    int m_enter = 0;

    always #5 clk = ~clk;

    rpsc_ps_sequencer #(
        .CNT_W(8), .G1_TIMEOUT(G1_TO), .AN_DELAY(AN_DLY),
        .AN_TIMEOUT(AN_TO), .OFF_DELAY(OFF_DL)
    ) dut (
        .clk(clk), .reset(reset),
        .i_start_req(start_req), .i_stop_req(stop_req), .i_fault_clear(fault_clear),
        .i_g1_not_alarm(g1_not_alarm), .i_not_g1_ok(not_g1_ok),
        .i_an_not_alarm(an_not_alarm), .i_an_perm(an_perm), .i_an_ok(an_ok),
        .o_g1_ps_act(g1_act), .o_an_ps_act(an_act), .o_running(running),
        .o_fault(fault), .o_fault_code(fault_code), .o_state(state)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A state is left once it has been occupied for "dwell" cycles equal to the limit.
    task automatic model_step();
        int ns, nc, dw;
        m_edge++;
        dw = m_edge - m_enter;
        ns = m_state;
        nc = m_code;
        if (!reset) begin
            ns = 0;
            nc = 0;
        end else begin
            case (m_state)
                0: if (start_req && g1_not_alarm && an_not_alarm) ns = 1;
                1, 2, 3, 4: begin
                    if (!g1_not_alarm) begin ns = 6; nc = 1; end
                    else if (m_state >= 2 && !an_not_alarm) begin ns = 6; nc = 3; end
                    else if (m_state == 4 && not_g1_ok) begin ns = 6; nc = 5; end
                    else if (m_state == 4 && !an_ok) begin ns = 6; nc = 6; end
                    else if (stop_req) ns = 5;
                    else if (m_state == 1) begin
                        if (!not_g1_ok) ns = 2;
                        else if (dw == G1_TO) begin ns = 6; nc = 2; end
                    end else if (m_state == 2) begin
                        if (dw == AN_DLY) begin
                            if (an_perm) ns = 3;
                            else begin ns = 6; nc = 3; end
                        end
                    end else if (m_state == 3) begin
                        if (an_ok) ns = 4;
                        else if (dw == AN_TO) begin ns = 6; nc = 4; end
                    end
                end
                5: begin
                    if (!g1_not_alarm) begin ns = 6; nc = 1; end
                    else if (dw == OFF_DL) ns = 0;
                end
                default: if (fault_clear && g1_not_alarm && an_not_alarm) begin ns = 0; nc = 0; end
            endcase
        end
        if (ns != m_state || !reset) m_enter = m_edge;
        m_state = ns;
        m_code  = nc;
    endtask

    // One clock: the model consumes the same inputs the DUT samples, then all
    // outputs are compared mid-cycle.
    task automatic tick();
        int exp_vec, act_vec;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_vec = {29'd0, (m_state >= 1 && m_state <= 5), (m_state == 3 || m_state == 4), 1'b0};
        exp_vec = exp_vec | ((m_state == 4) ? 1 : 0) | ((m_state == 6) ? 8 : 0);
        act_vec = {28'd0, fault, g1_act, an_act, running};
        chk("state", int'(state), m_state);
        chk("code", int'(fault_code), m_code);
        chk("acts{fault,g1,an,run}", act_vec, exp_vec);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic quiet();
        start_req = 0; stop_req = 0; fault_clear = 0;
        g1_not_alarm = 1; an_not_alarm = 1; an_perm = 1;
        not_g1_ok = 1; an_ok = 0;
    endtask

    task automatic go_run();
        start_req = 1;
        tick();
        start_req = 0;
        not_g1_ok = 0;
        tick();
        ticks(AN_DLY);
        an_ok = 1;
        tick();
        chk("go_run_state", int'(state), 4);
    endtask

    initial begin
        reset = 0;
        quiet();
        ticks(2);
        chk("reset_state", int'(state), 0);
        chk("reset_g1", int'(g1_act), 0);
        reset = 1;
        tick();

        // Normal start
        start_req = 1;
        tick();
        chk("start_g1_act", int'(g1_act), 1);
        chk("start_an_act", int'(an_act), 0);
        start_req = 0;
        ticks(2);
        not_g1_ok = 0;
        tick();
        chk("an_wait_state", int'(state), 2);
        ticks(AN_DLY - 1);
        chk("an_wait_4th", int'(an_act), 0);
        tick();
        chk("an_act_after_5", int'(an_act), 1);
        ticks(3);
        an_ok = 1;
        tick();
        chk("run_state", int'(state), 4);
        chk("run_running", int'(running), 1);

        // Ordered stop
        stop_req = 1;
        tick();
        stop_req = 0;
        chk("stop_an_off", int'(an_act), 0);
        chk("stop_g1_on", int'(g1_act), 1);
        ticks(OFF_DL - 1);
        chk("stop_g1_4th", int'(g1_act), 1);
        tick();
        chk("stop_g1_off", int'(g1_act), 0);
        chk("stop_idle", int'(state), 0);
        chk("stop_nofault", int'(fault), 0);

        // G1 timeout
        quiet();
        start_req = 1;
        tick();
        start_req = 0;
        ticks(G1_TO - 1);
        chk("g1to_19", int'(state), 1);
        tick();
        chk("g1to_fault", int'(state), 6);
        chk("g1to_code", int'(fault_code), 2);
        chk("g1to_acts", int'({g1_act, an_act}), 0);
        fault_clear = 1;
        tick();
        fault_clear = 0;
        chk("g1to_clear", int'(state), 0);
        chk("g1to_code0", int'(fault_code), 0);

        // Anode alarm with simultaneous stop
        quiet();
        go_run();
        an_not_alarm = 0;
        stop_req = 1;
        tick();
        stop_req = 0;
        chk("analarm_code", int'(fault_code), 3);
        chk("analarm_state", int'(state), 6);
        fault_clear = 1;
        tick();
        chk("analarm_hold", int'(state), 6);
        an_not_alarm = 1;
        tick();
        fault_clear = 0;
        chk("analarm_clear", int'(state), 0);

        // Anode timeout and first-fault latch
        quiet();
        start_req = 1;
        tick();
        start_req = 0;
        not_g1_ok = 0;
        tick();
        ticks(AN_DLY);
        chk("anto_ramp", int'(state), 3);
        ticks(AN_TO - 1);
        chk("anto_29", int'(state), 3);
        tick();
        chk("anto_code", int'(fault_code), 4);
        g1_not_alarm = 0;
        ticks(3);
        chk("anto_latched", int'(fault_code), 4);
        g1_not_alarm = 1;
        fault_clear = 1;
        tick();
        fault_clear = 0;

        // Reset mid-RUN
        quiet();
        go_run();
        reset = 0;
        tick();
        reset = 1;
        chk("rst_state", int'(state), 0);
        chk("rst_acts", int'({g1_act, an_act, running, fault}), 0);
        g1_not_alarm = 0;
        start_req = 1;
        tick();
        chk("rst_alarm_start", int'(state), 0);
        quiet();
        tick();

        // Randomized operation in segments with different input profiles
        for (int seg = 0; seg < 80; seg++) begin
            int prof;
            prof = $urandom_range(0, 3);
            for (int c = 0; c < 64; c++) begin
                reset        = ($urandom_range(0, 499) != 0);
                start_req    = ($urandom_range(0, 3) == 0);
                stop_req     = ($urandom_range(0, 59) == 0);
                fault_clear  = ($urandom_range(0, 7) == 0);
                g1_not_alarm = ($urandom_range(0, 199) != 0);
                an_not_alarm = ($urandom_range(0, 199) != 0);
                not_g1_ok    = (prof == 0) ? 1'b1 : ($urandom_range(0, 149) == 0);
                an_ok        = (prof == 1) ? 1'b0 : ($urandom_range(0, 149) != 0);
                an_perm      = (prof == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
